// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_unit_pkg;

    localparam int MD_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_e;

endpackage

// File: rtl/muldiv_unit_div_radix2_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, WIDTH bits in total.
// The first bit is produced in the start cycle straight from the input operands.
module div_radix2_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_r, quo_r, dsr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] rem_src_s, quo_src_s, dsr_src_s;
    logic [WIDTH-1:0] rem_nxt_s, quo_nxt_s;
    logic [WIDTH:0]   shifted_s, diff_s;

    // One restoring step; a borrow out of the trial subtraction means the bit is 0
    always_comb begin
        if (start) begin
            rem_src_s = {WIDTH{1'b0}};
            quo_src_s = dividend;
            dsr_src_s = divisor;
        end else begin
            rem_src_s = rem_r;
            quo_src_s = quo_r;
            dsr_src_s = dsr_r;
        end
        shifted_s = {rem_src_s, quo_src_s[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, dsr_src_s};
        if (diff_s[WIDTH]) begin
            rem_nxt_s = shifted_s[WIDTH-1:0];
            quo_nxt_s = {quo_src_s[WIDTH-2:0], 1'b0};
        end else begin
            rem_nxt_s = diff_s[WIDTH-1:0];
            quo_nxt_s = {quo_src_s[WIDTH-2:0], 1'b1};
        end
    end

    // Iteration registers; count_r holds the number of steps still to run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            dsr_r   <= {WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (cancel) begin
            count_r <= {CW{1'b0}};
        end else if (start) begin
            rem_r   <= rem_nxt_s;
            quo_r   <= quo_nxt_s;
            dsr_r   <= divisor;
            count_r <= CW'(WIDTH - 1);
        end else if (count_r != {CW{1'b0}}) begin
            rem_r   <= rem_nxt_s;
            quo_r   <= quo_nxt_s;
            count_r <= count_r - CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // done marks the cycle whose closing edge stores the final quotient bit
    assign done      = (count_r == CW'(1));
    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with a HI/LO register pair for the execute stage.
// Multiplies finish after MUL_LAT cycles; divides run a restoring core followed by a sign-fix cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH   = MD_WIDTH_DEFAULT,
    parameter int MUL_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_src1,
    input  logic [WIDTH-1:0] req_src2,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_hi,
    output logic [WIDTH-1:0] resp_lo,
    input  logic             hi_wen,
    input  logic             lo_wen,
    input  logic [WIDTH-1:0] hi_wdata,
    input  logic [WIDTH-1:0] lo_wdata,
    output logic [WIDTH-1:0] hi_rdata,
    output logic [WIDTH-1:0] lo_rdata,
    output logic             busy
);
    md_state_e          state_r, state_nxt_s;
    logic [2:0]         mul_cnt_r;
    logic [WIDTH-1:0]   a_r, b_r;
    logic               sgn_r, neg_q_r, neg_r_r;
    logic [WIDTH-1:0]   res_hi_r, res_lo_r, hi_r, lo_r;
    logic               resp_valid_r, busy_r;

    logic               ready_s, accept_s, div_zero_s, req_sgn_s;
    logic               src1_neg_s, src2_neg_s, commit_s, res_load_s, div_start_s;
    logic [WIDTH-1:0]   mag1_s, mag2_s, mul_a_s, mul_b_s;
    logic [WIDTH-1:0]   res_hi_nxt_s, res_lo_nxt_s;
    logic               mul_sgn_s;
    logic [2*WIDTH-1:0] mul_a_ext_s, mul_b_ext_s, prod_s;
    logic               div_done_s;
    logic [WIDTH-1:0]   div_quo_s, div_rem_s;

    // Request decode: handshake, commit condition and divider operand magnitudes
    always_comb begin
        ready_s     = (state_r == IDLE) && !flush;
        accept_s    = req_valid && ready_s;
        commit_s    = (state_r == DONE) && resp_ready && !flush;
        div_zero_s  = (req_src2 == {WIDTH{1'b0}});
        req_sgn_s   = !req_op[0];
        src1_neg_s  = req_sgn_s && req_src1[WIDTH-1];
        src2_neg_s  = req_sgn_s && req_src2[WIDTH-1];
        div_start_s = accept_s && req_op[1] && !div_zero_s;
        if (src1_neg_s) begin
            mag1_s = -req_src1;
        end else begin
            mag1_s = req_src1;
        end
        if (src2_neg_s) begin
            mag2_s = -req_src2;
        end else begin
            mag2_s = req_src2;
        end
    end

    // Multiplier: request operands on the accept cycle, latched ones while in MUL
    always_comb begin
        if (state_r == IDLE) begin
            mul_a_s   = req_src1;
            mul_b_s   = req_src2;
            mul_sgn_s = req_sgn_s;
        end else begin
            mul_a_s   = a_r;
            mul_b_s   = b_r;
            mul_sgn_s = sgn_r;
        end
        // Low 2W bits of the extended product are correct for both signed and unsigned
        mul_a_ext_s = {{WIDTH{mul_sgn_s & mul_a_s[WIDTH-1]}}, mul_a_s};
        mul_b_ext_s = {{WIDTH{mul_sgn_s & mul_b_s[WIDTH-1]}}, mul_b_s};
        prod_s      = mul_a_ext_s * mul_b_ext_s;
    end

    // Next-state logic; flush returns every busy state to IDLE and blocks accepts
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!accept_s) begin
                        state_nxt_s = IDLE;
                    end else if (!req_op[1]) begin
                        if (MUL_LAT == 1) begin
                            state_nxt_s = DONE;
                        end else begin
                            state_nxt_s = MUL;
                        end
                    end else if (div_zero_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = DIV;
                    end
                end
                MUL: begin
                    if (mul_cnt_r == 3'(MUL_LAT - 2)) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = MUL;
                    end
                end
                DIV: begin
                    if (div_done_s) begin
                        state_nxt_s = FIX;
                    end else begin
                        state_nxt_s = DIV;
                    end
                end
                FIX:  state_nxt_s = DONE;
                DONE: begin
                    if (resp_ready) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Result selection, loaded only on the transition into DONE
    always_comb begin
        res_hi_nxt_s = res_hi_r;
        res_lo_nxt_s = res_lo_r;
        case (state_r)
            IDLE: begin
                if (req_op[1]) begin
                    res_hi_nxt_s = req_src1;
                    res_lo_nxt_s = {WIDTH{1'b1}};
                end else begin
                    {res_hi_nxt_s, res_lo_nxt_s} = prod_s;
                end
            end
            MUL: {res_hi_nxt_s, res_lo_nxt_s} = prod_s;
            FIX: begin
                if (neg_q_r) begin
                    res_lo_nxt_s = -div_quo_s;
                end else begin
                    res_lo_nxt_s = div_quo_s;
                end
                if (neg_r_r) begin
                    res_hi_nxt_s = -div_rem_s;
                end else begin
                    res_hi_nxt_s = div_rem_s;
                end
            end
            default: begin
                res_hi_nxt_s = res_hi_r;
                res_lo_nxt_s = res_lo_r;
            end
        endcase
        res_load_s = (state_nxt_s == DONE) && (state_r != DONE);
    end

    // Control and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            mul_cnt_r    <= 3'd0;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            sgn_r        <= 1'b0;
            neg_q_r      <= 1'b0;
            neg_r_r      <= 1'b0;
            res_hi_r     <= {WIDTH{1'b0}};
            res_lo_r     <= {WIDTH{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            resp_valid_r <= (state_nxt_s == DONE);
            busy_r       <= (state_nxt_s != IDLE);
            if (accept_s) begin
                mul_cnt_r <= 3'd0;
                a_r       <= req_src1;
                b_r       <= req_src2;
                sgn_r     <= req_sgn_s;
                neg_q_r   <= req_op[1] && (src1_neg_s ^ src2_neg_s);
                neg_r_r   <= req_op[1] && src1_neg_s;
            end else if (state_r == MUL) begin
                mul_cnt_r <= mul_cnt_r + 3'd1;
            end else begin
                mul_cnt_r <= mul_cnt_r;
            end
            if (res_load_s) begin
                res_hi_r <= res_hi_nxt_s;
                res_lo_r <= res_lo_nxt_s;
            end else begin
                res_hi_r <= res_hi_r;
                res_lo_r <= res_lo_r;
            end
        end
    end

    // HI/LO architectural registers; a direct write beats the commit per register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else begin
            if (hi_wen) begin
                hi_r <= hi_wdata;
            end else if (commit_s) begin
                hi_r <= res_hi_r;
            end else begin
                hi_r <= hi_r;
            end
            if (lo_wen) begin
                lo_r <= lo_wdata;
            end else if (commit_s) begin
                lo_r <= res_lo_r;
            end else begin
                lo_r <= lo_r;
            end
        end
    end

    div_radix2_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start_s),
        .cancel    (flush),
        .dividend  (mag1_s),
        .divisor   (mag2_s),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    assign req_ready  = ready_s;
    assign resp_valid = resp_valid_r;
    assign resp_hi    = res_hi_r;
    assign resp_lo    = res_lo_r;
    assign hi_rdata   = hi_r;
    assign lo_rdata   = lo_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences and random ops vs a model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W      = 32;
    localparam int ML     = 1;
    localparam int DIVLAT = W + 1;

    logic         clk, reset, req_valid, req_ready, flush, resp_valid, resp_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_src1, req_src2, resp_hi, resp_lo;
    logic         hi_wen, lo_wen, busy;
    logic [W-1:0] hi_wdata, lo_wdata, hi_rdata, lo_rdata;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] hi_m, lo_m;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
        int           lat;
    } vec_t;
    vec_t vecs[9];

    muldiv_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hi(resp_hi), .resp_lo(resp_lo),
        .hi_wen(hi_wen), .lo_wen(lo_wen), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .hi_rdata(hi_rdata), .lo_rdata(lo_rdata), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: MIPS-style HI/LO results from plain integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sp;
        longint unsigned up;
        int              q, r;
        case (op)
            2'b00: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp; end
            2'b01: begin up = longint'({32'd0, a}) * longint'({32'd0, b}); return up; end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [W-1:0] b);
        if (!op[1]) return ML;
        if (b == 32'd0) return 1;
        return DIVLAT;
    endfunction

    // Issue one op, measure latency, hold the response, then commit (optionally with MTHI in the commit cycle)
    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input int elat, input int hold,
                          input logic mthi, input logic [W-1:0] mthi_d);
        int n;
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check({name, "_accept"}, 128'(n < 50), 128'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check({name, "_latency"}, 128'(lat), 128'(elat));
        check({name, "_result"}, {resp_hi, resp_lo}, {ehi, elo});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, "_hold"}, {resp_valid, resp_hi, resp_lo}, {1'b1, ehi, elo});
        end
        @(negedge clk);
        resp_ready = 1'b1; hi_wen = mthi; hi_wdata = mthi_d;
        @(posedge clk); #1;
        resp_ready = 1'b0; hi_wen = 1'b0;
        hi_m = mthi ? mthi_d : ehi;
        lo_m = elo;
        check({name, "_commit"}, {resp_valid, hi_rdata, lo_rdata}, {1'b0, hi_m, lo_m});
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        logic [63:0]  rexp;
        logic         seen;

        vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, ML};
        vecs[1] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       DIVLAT};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIVLAT};
        vecs[3] = '{2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1};
        vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DIVLAT};
        vecs[5] = '{2'b11, 32'd7,        32'd100,      32'd7,        32'd0,        DIVLAT};
        vecs[6] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DIVLAT};
        vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        ML};
        vecs[8] = '{2'b01, 32'hFFFFFFFF, 32'd3,        32'd2,        32'hFFFFFFFD, ML};

        reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_src1 = '0; req_src2 = '0;
        flush = 1'b0; resp_ready = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0; hi_wdata = '0; lo_wdata = '0;
        hi_m = '0; lo_m = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_state", {busy, resp_valid, req_ready, resp_hi, resp_lo, hi_rdata, lo_rdata},
              {1'b0, 1'b0, 1'b1, 128'd0});

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].lat, i % 3, 1'b0, '0);

        // Response held 5 cycles, MTHI lands in the commit cycle
        run_op("hold_mthi", MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE, ML, 5, 1'b1, 32'hAA);

        // Flush at cycle 10 of a DIVU
        @(negedge clk);
        req_valid = 1'b1; req_op = MD_DIVU; req_src1 = 32'd1000; req_src2 = 32'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 check("div_busy", {busy, req_ready, resp_valid}, 3'b100);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_idle", {busy, resp_valid}, 2'b00);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
        check("flush_no_resp", seen, 1'b0);
        check("flush_hilo", {hi_rdata, lo_rdata}, {hi_m, lo_m});
        run_op("after_flush", vecs[1].op, vecs[1].a, vecs[1].b, vecs[1].hi, vecs[1].lo, vecs[1].lat, 0, 1'b0, '0);

        // Flush with req_valid in IDLE: no accept
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_op = MD_MULT; req_src1 = 32'd3; req_src2 = 32'd4;
        #1 check("flush_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        check("flush_no_accept", {busy, resp_valid}, 2'b00);
        @(negedge clk); flush = 1'b0; req_valid = 1'b0;

        // MTLO in IDLE
        @(negedge clk); lo_wen = 1'b1; lo_wdata = 32'hCAFE0001;
        @(posedge clk); #1; lo_wen = 1'b0;
        lo_m = 32'hCAFE0001;
        check("mtlo", {hi_rdata, lo_rdata}, {hi_m, lo_m});

        // Flush in the handshake cycle: no commit
        @(negedge clk);
        req_valid = 1'b1; req_op = MD_MULT; req_src1 = 32'd6; req_src2 = 32'd7;
        @(posedge clk); #1; req_valid = 1'b0;
        check("fh_valid", {resp_valid, resp_lo}, {1'b1, 32'd42});
        @(negedge clk); resp_ready = 1'b1; flush = 1'b1;
        @(posedge clk); #1; resp_ready = 1'b0; flush = 1'b0;
        check("flush_vs_commit", {resp_valid, busy, hi_rdata, lo_rdata}, {2'b00, hi_m, lo_m});

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 200));
            rexp = model(rop, ra, rb);
            run_op($sformatf("rand%0d", i), rop, ra, rb, rexp[63:32], rexp[31:0],
                   model_lat(rop, rb), $urandom_range(0, 2), 1'b0, '0);
        end

        // Asynchronous reset mid-DIV, applied between clock edges
        @(negedge clk); hi_wen = 1'b1; lo_wen = 1'b1; hi_wdata = 32'h1234; lo_wdata = 32'h5678;
        @(negedge clk); hi_wen = 1'b0; lo_wen = 1'b0;
        req_valid = 1'b1; req_op = MD_DIV; req_src1 = 32'd999; req_src2 = 32'd5;
        @(posedge clk); #1; req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset", {busy, resp_valid, hi_rdata, lo_rdata, resp_hi, resp_lo}, 130'd0);
        @(negedge clk); reset = 1'b0;
        #1 check("post_reset_ready", {req_ready, busy}, 2'b10);
        hi_m = '0; lo_m = '0;
        run_op("post_reset_op", vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].hi, vecs[0].lo, vecs[0].lat, 1, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with an internal HI/LO register pair, for use in the execute stage.
- Accepts one MULT/MULTU/DIV/DIVU request per valid/ready handshake and runs a radix-2 restoring divider or a delayed multiplier.
- Presents {hi, lo} on a valid/ready response port and commits the result to HI/LO on the response handshake.
- Supports pipeline flush (cancel mid-operation) and direct MTHI/MTLO writes; the execute stage stalls on !resp_valid.

Parameters:
- WIDTH, 32: operand width; HI/LO are each WIDTH bits; product and {rem, quot} are 2*WIDTH bits.
- MUL_LAT, 1: cycles from request accept to resp_valid for multiplies; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE and only when flush is low.
- req_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- req_src1  in  WIDTH  multiplicand or dividend (rs).
- req_src2  in  WIDTH  multiplier or divisor (rt).
- flush  in  1  cancels any in-flight operation.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_hi  out  WIDTH  product[2W-1:W], or remainder.
- resp_lo  out  WIDTH  product[W-1:0], or quotient.
- hi_wen  in  1  direct HI write (MTHI).
- lo_wen  in  1  direct LO write (MTLO).
- hi_wdata  in  WIDTH  direct HI write data.
- lo_wdata  in  WIDTH  direct LO write data.
- hi_rdata  out  WIDTH  current HI.
- lo_rdata  out  WIDTH  current LO.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; counters = 0; HI = LO = 0.
  - Outputs: resp_valid = 0, resp_hi = resp_lo = 0, busy = 0, req_ready = 1 (while flush is low).
- Accept: req_valid && req_ready at a rising edge. Operands, op, and signedness are latched; inputs are ignored until the unit returns to IDLE.
- States and transitions:
  - IDLE -> MUL (op[1] == 0).
  - IDLE -> DIV (op[1] == 1, divisor != 0).
  - IDLE -> DONE (op[1] == 1, divisor == 0).
  - MUL: counter runs MUL_LAT-1 cycles -> DONE. With MUL_LAT == 1, the transition is immediate, so resp_valid rises 1 cycle after accept.
  - DIV: operates on magnitudes (abs value for signed ops). One quotient bit per cycle for WIDTH cycles -> FIX.
  - FIX: applies signs -> DONE. Quotient is negative iff the operand signs differ; remainder takes the dividend's sign. resp_valid rises WIDTH+1 cycles after accept (33 at default).
  - DONE: resp_valid = 1; resp_hi/resp_lo are held stable while resp_ready is low. On resp_valid && resp_ready: HI <= resp_hi, LO <= resp_lo, -> IDLE.
- Arithmetic rules:
  - MULT uses a signed 2W product; MULTU uses an unsigned one.
  - Divide by zero: quotient = all ones, remainder = dividend; latency 1.
  - Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0. No trap.
- Flush:
  - In any non-IDLE state: -> IDLE at the next edge; resp_valid drops; HI/LO are not written.
  - Flush in the same cycle as resp handshake: flush wins, no commit.
  - Flush with req_valid in IDLE: no accept.
- Direct writes:
  - hi_wen/lo_wen write HI/LO at the edge in any state.
  - If asserted in the same cycle as a commit, the direct write wins for that register; the other register takes the commit value.
- hi_rdata/lo_rdata are the registered HI/LO values, with no bypass.
- Back-to-back operation: after a commit the unit is in IDLE, so a new request can be accepted in the next cycle.

Decomposition:
- Shared package: op encodings (MD_MULT/MD_MULTU/MD_DIV/MD_DIVU), state encodings (IDLE/MUL/DIV/FIX/DONE), WIDTH default.
- Sub-module div_radix2_core: magnitude restoring divider with start, WIDTH-cycle iteration, and done. Sign handling stays in the parent.

Test Plan:
- MULT -3 x 7 (WIDTH = 32, MUL_LAT = 1) -> resp_valid 1 cycle after accept; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; HI/LO updated after handshake.
- DIVU 100 / 7 -> resp_valid exactly 33 cycles after accept; lo = 14, hi = 2. DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIV 5 / 0 -> resp_valid 1 cycle after accept; lo = 0xFFFFFFFF, hi = 5. DIV 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
- Flush at cycle 10 of a DIVU -> busy drops next cycle; resp_valid never rises; HI/LO unchanged; next request accepted normally.
- resp_ready held low 5 cycles in DONE with MULTU 0xFFFFFFFF x 2 -> hi = 1, lo = 0xFFFFFFFE stable throughout; hi_wen = 1 with hi_wdata = 0xAA in the commit cycle -> HI = 0xAA, LO = 0xFFFFFFFE.
- Reset asserted mid-DIV (asynchronous, between edges) -> busy, resp_valid, HI, LO = 0 immediately; req_ready = 1 after release.
